tod_transmitter: RTL and testbench

Upstream time-of-day source for the EVR timestamp receiver. On each GPS/NTP PPS strobe it emits the seconds-marker event code. It then serialises the *next* second's value as SECONDS_WIDTH shift-zero/shift-one events, MSB first, onto an event-code stream with a valid/ready handshake. It sits in the event generator, feeding the event-stream arbiter that drives the link.

---
 rtl/tod_transmitter.sv | 192 +++++++++++++++++++
 tb/tb_tod_transmitter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tod_transmitter.sv
// tod_transmitter: upstream time-of-day source for the EVR timestamp receiver.
//
// Each PPS strobe emits the seconds-marker event code. The block then
// serialises the value the receiver will latch at the *next* marker
// (secondsNow+1) as SECONDS_WIDTH shift-zero/shift-one events, MSB first.
// Consecutive events are separated by at least BIT_SPACING clocks.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   enable            allow event emission (an in-flight handshake still completes)
//   pps               single-cycle PPS strobe, already synchronous to clk
//   secondsLoad       load secondsIn into secondsNow (wins over pps)
//   secondsIn         seconds value to load
//   evCode            event code, valid while evCodeValid
//   evCodeValid       event pending; held with evCode until evCodeReady
//   evCodeReady       downstream arbiter accepts evCode this cycle
//   secondsNow        current seconds count
//   busy              a sequence is pending or in progress
//   overrunCounter    PPS arrivals while busy (saturating)
//   ppsMissedCounter  PPS watchdog timeouts (saturating)
module tod_transmitter #(
  parameter int unsigned NOMINAL_CLK_RATE      = 125_000_000,
  parameter int unsigned SECONDS_WIDTH         = 32,
  parameter logic [7:0]  EVCODE_SHIFT_ZERO     = 8'h70,
  parameter logic [7:0]  EVCODE_SHIFT_ONE      = 8'h71,
  parameter logic [7:0]  EVCODE_SECONDS_MARKER = 8'h7D,
  parameter int unsigned BIT_SPACING           = 16,
  parameter int unsigned STATUS_COUNTER_WIDTH  = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic                            pps,
  input  logic                            secondsLoad,
  input  logic [SECONDS_WIDTH-1:0]        secondsIn,
  output logic [7:0]                      evCode,
  output logic                            evCodeValid,
  input  logic                            evCodeReady,
  output logic [SECONDS_WIDTH-1:0]        secondsNow,
  output logic                            busy,
  output logic [STATUS_COUNTER_WIDTH-1:0] overrunCounter,
  output logic [STATUS_COUNTER_WIDTH-1:0] ppsMissedCounter
);

  localparam int unsigned WATCHDOG_LIMIT = NOMINAL_CLK_RATE + NOMINAL_CLK_RATE / 100;
  localparam int unsigned TIMER_WIDTH    = $clog2(WATCHDOG_LIMIT + 1);
  localparam int unsigned GAP_WIDTH      = $clog2(BIT_SPACING + 1);
  localparam int unsigned BITS_WIDTH     = $clog2(SECONDS_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MARKER = 2'd1,
    GAP    = 2'd2,
    SHIFT  = 2'd3
  } stateType;

  stateType                 state;
  stateType                 nextState;
  logic [SECONDS_WIDTH-1:0] shiftReg;
  logic [BITS_WIDTH-1:0]    bitsLeft;
  logic [GAP_WIDTH-1:0]     gapCount;
  logic                     ppsPending;
  logic [TIMER_WIDTH-1:0]   wdTimer;

  logic transfer;
  logic gapDone;

  assign transfer = evCodeValid && evCodeReady;
  // gapCount is preloaded with BIT_SPACING-1 outside GAP, so the GAP state
  // lasts exactly BIT_SPACING-1 clocks.
  assign gapDone  = (gapCount == GAP_WIDTH'(1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: nextState gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (pps && enable) nextState = MARKER;
      end
      MARKER: begin
        // A pps here is counted as an overrun but does not queue another marker.
        if (transfer) begin
          if (!enable)              nextState = IDLE;
          else if (BIT_SPACING > 1) nextState = GAP;
          else                      nextState = SHIFT;
        end
      end
      GAP: begin
        // An overrun pps aborts the remaining bits and restarts with a marker.
        if (!enable)            nextState = IDLE;
        else if (pps)           nextState = MARKER;
        else if (gapDone)       nextState = (bitsLeft != '0) ? SHIFT : IDLE;
      end
      SHIFT: begin
        // The current bit always completes its handshake before any redirect.
        if (transfer) begin
          if (!enable)                  nextState = IDLE;
          else if (pps || ppsPending)   nextState = MARKER;
          else if (BIT_SPACING > 1)     nextState = GAP;
          else if (bitsLeft > BITS_WIDTH'(1)) nextState = SHIFT;
          else                          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (Moore: purely from state and shift register, so code and
  // valid are stable for as long as the state holds awaiting a transfer)
  // ---------------------------------------------------------------------------
  always_comb begin
    evCode      = 8'h00;
    evCodeValid = 1'b0;
    unique case (state)
      MARKER: begin
        evCode      = EVCODE_SECONDS_MARKER;
        evCodeValid = 1'b1;
      end
      SHIFT: begin
        evCode      = shiftReg[SECONDS_WIDTH-1] ? EVCODE_SHIFT_ONE : EVCODE_SHIFT_ZERO;
        evCodeValid = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Datapath: seconds counter, shift register, gap timer, status counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      secondsNow       <= '0;
      shiftReg         <= '0;
      bitsLeft         <= '0;
      gapCount         <= '0;
      ppsPending       <= 1'b0;
      wdTimer          <= '0;
      overrunCounter   <= '0;
      ppsMissedCounter <= '0;
    end else begin
      // A load wins over a simultaneous pps; both act regardless of enable.
      if (secondsLoad)  secondsNow <= secondsIn;
      else if (pps)     secondsNow <= secondsNow + 1'b1;

      // Capture the value the receiver will latch at the following marker.
      if (state == MARKER && transfer) begin
        shiftReg <= secondsNow + 1'b1;
        bitsLeft <= BITS_WIDTH'(SECONDS_WIDTH);
      end else if (state == SHIFT && transfer) begin
        shiftReg <= shiftReg << 1;
        bitsLeft <= bitsLeft - 1'b1;
      end

      if (state != GAP) gapCount <= GAP_WIDTH'(BIT_SPACING - 1);
      else              gapCount <= gapCount - 1'b1;

      // Remember an overrun pps seen while a shift event is stalled, so the
      // redirect to MARKER happens once that handshake completes.
      ppsPending <= (state == SHIFT) && !transfer && (ppsPending || pps);

      if (pps && busy && (overrunCounter != '1))
        overrunCounter <= overrunCounter + 1'b1;

      if (pps) begin
        wdTimer <= '0;
      end else if (wdTimer == TIMER_WIDTH'(WATCHDOG_LIMIT - 1)) begin
        wdTimer <= '0;
        if (ppsMissedCounter != '1) ppsMissedCounter <= ppsMissedCounter + 1'b1;
      end else begin
        wdTimer <= wdTimer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tod_transmitter.sv
// tb_tod_transmitter: directed self-checking bench for tod_transmitter.
// Uses BIT_SPACING=4 and a reduced NOMINAL_CLK_RATE=1000 (watchdog at 1010).
// A negedge monitor logs every transferred event and feeds a small
// time-of-day receiver model for the loopback checks.
module tb_tod_transmitter;

  localparam int SW  = 32;
  localparam int BS  = 4;
  localparam int NCR = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          pps;
  logic          secondsLoad;
  logic [SW-1:0] secondsIn;
  logic [7:0]    evCode;
  logic          evCodeValid;
  logic          evCodeReady;
  logic [SW-1:0] secondsNow;
  logic          busy;
  logic [9:0]    overrunCounter;
  logic [9:0]    ppsMissedCounter;

  tod_transmitter #(
    .NOMINAL_CLK_RATE     (NCR),
    .SECONDS_WIDTH        (SW),
    .EVCODE_SHIFT_ZERO    (8'h70),
    .EVCODE_SHIFT_ONE     (8'h71),
    .EVCODE_SECONDS_MARKER(8'h7D),
    .BIT_SPACING          (BS),
    .STATUS_COUNTER_WIDTH (10)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .pps             (pps),
    .secondsLoad     (secondsLoad),
    .secondsIn       (secondsIn),
    .evCode          (evCode),
    .evCodeValid     (evCodeValid),
    .evCodeReady     (evCodeReady),
    .secondsNow      (secondsNow),
    .busy            (busy),
    .overrunCounter  (overrunCounter),
    .ppsMissedCounter(ppsMissedCounter)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Event monitor and receiver model
  int          cycle = 0;
  byte unsigned evLog[$];
  int          evCycle[$];
  logic [SW-1:0] rxShift = '0;
  logic [SW-1:0] rxSec   = '0;
  int          rxBits  = 0;
  bit          rxValid = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    if (!rst && evCodeValid && evCodeReady) begin
      evLog.push_back(evCode);
      evCycle.push_back(cycle);
      if (evCode == 8'h7D) begin
        rxValid = (rxBits == SW);
        if (rxBits == SW) rxSec = rxShift;
        rxBits = 0;
      end else begin
        rxShift = {rxShift[SW-2:0], (evCode == 8'h71)};
        rxBits  = rxBits + 1;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulsePps();
    pps = 1'b1;
    tick();
    pps = 1'b0;
  endtask

  task automatic waitEvents(input string tag, input int n, input int budget);
    int k = 0;
    while (evLog.size() < n && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_event_count"}, evLog.size(), n);
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_idle"}, busy, 0);
  endtask

  // Decode SW bit events starting at log index first; bad counts non-bit codes.
  task automatic decodeSeq(input int first, output logic [SW-1:0] value, output int bad);
    value = '0;
    bad   = 0;
    for (int i = 0; i < SW; i++) begin
      byte unsigned c;
      c = (first + i < evLog.size()) ? evLog[first + i] : 8'h00;
      if (c != 8'h70 && c != 8'h71) bad++;
      value = {value[SW-2:0], (c == 8'h71)};
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [SW-1:0] expSec;
    logic [SW-1:0] val;
    logic [7:0]    holdCode;
    logic [7:0]    expCode;
    logic [SW-1:0] expShift;
    int            bad;
    int            k;

    rst = 1'b1; enable = 1'b1; pps = 1'b0; secondsLoad = 1'b0;
    secondsIn = '0; evCodeReady = 1'b1;
    tick(3);
    check("rst_valid",   evCodeValid, 0);
    check("rst_code",    evCode, 0);
    check("rst_seconds", secondsNow, 0);
    check("rst_busy",    busy, 0);
    check("rst_overrun", overrunCounter, 0);
    check("rst_missed",  ppsMissedCounter, 0);
    rst = 1'b0;
    tick();

    // 1. Basic sequence
    secondsIn = 32'h1234_5678; secondsLoad = 1'b1;
    tick();
    secondsLoad = 1'b0;
    check("t1_load", secondsNow, 32'h1234_5678);
    evLog.delete(); evCycle.delete();
    pulsePps();
    expSec = 32'h1234_5679;
    check("t1_marker_valid", evCodeValid, 1);
    check("t1_marker_code",  evCode, 8'h7D);
    check("t1_seconds",      secondsNow, expSec);
    check("t1_busy",         busy, 1);
    waitEvents("t1", 1 + SW, 400);
    check("t1_first_is_marker", evLog[0], 8'h7D);
    decodeSeq(1, val, bad);
    check("t1_bad_codes", bad, 0);
    check("t1_value", val, 32'h1234_567A);
    check("t1_bit0_code", evLog[1], 8'h70);
    check("t1_bit3_code", evLog[4], 8'h71);
    bad = 0;
    for (int i = 1; i < evCycle.size(); i++)
      if (evCycle[i] - evCycle[i-1] != BS) bad++;
    check("t1_spacing", bad, 0);
    waitIdle("t1", 20);
    check("t1_overrun", overrunCounter, 0);

    // 2. Backpressure on marker and bit 5
    evLog.delete();
    evCodeReady = 1'b0;
    pulsePps();
    expSec = expSec + 1;
    bad = 0;
    repeat (10) begin
      if (!(evCodeValid && evCode == 8'h7D)) bad++;
      tick();
    end
    check("t2_marker_stable", bad, 0);
    check("t2_no_early_transfer", evLog.size(), 0);
    evCodeReady = 1'b1;
    k = 0;
    while (evLog.size() < 6 && k < 200) begin tick(); k++; end
    evCodeReady = 1'b0;
    check("t2_six_events", evLog.size(), 6);
    k = 0;
    while (!evCodeValid && k < 20) begin tick(); k++; end
    expShift = expSec + 1;
    expCode  = expShift[SW-1-5] ? 8'h71 : 8'h70;
    holdCode = evCode;
    check("t2_bit5_code", holdCode, expCode);
    bad = 0;
    repeat (10) begin
      if (!(evCodeValid && evCode == holdCode)) bad++;
      tick();
    end
    check("t2_bit5_stable", bad, 0);
    check("t2_no_transfer_bit5", evLog.size(), 6);
    evCodeReady = 1'b1;
    waitEvents("t2", 1 + SW, 400);
    decodeSeq(1, val, bad);
    check("t2_bad_codes", bad, 0);
    check("t2_value", val, 32'h1234_567B);
    waitIdle("t2", 20);
    check("t2_overrun", overrunCounter, 0);

    // 3. Overrun in GAP after bit 7
    evLog.delete();
    pulsePps();
    expSec = expSec + 1;
    k = 0;
    while (evLog.size() < 9 && k < 200) begin tick(); k++; end
    check("t3_in_gap", evCodeValid, 0);
    pulsePps();
    expSec = expSec + 1;
    check("t3_overrun",     overrunCounter, 1);
    check("t3_remarker",    evCode, 8'h7D);
    check("t3_remarker_v",  evCodeValid, 1);
    check("t3_seconds",     secondsNow, 32'h1234_567C);
    waitEvents("t3", 9 + 1 + SW, 400);
    check("t3_log9_marker", evLog[9], 8'h7D);
    decodeSeq(10, val, bad);
    check("t3_bad_codes", bad, 0);
    check("t3_value", val, 32'h1234_567D);
    waitIdle("t3", 20);

    // 4. Load/pps collision
    evLog.delete();
    secondsIn = 32'h100; secondsLoad = 1'b1; pps = 1'b1;
    tick();
    secondsLoad = 1'b0; pps = 1'b0;
    expSec = 32'h100;
    check("t4_seconds", secondsNow, expSec);
    waitEvents("t4", 1 + SW, 400);
    decodeSeq(1, val, bad);
    check("t4_value", val, 32'h101);
    waitIdle("t4", 20);

    // 5. Enable low: no events, seconds still counts; then drop enable mid-sequence
    enable = 1'b0;
    evLog.delete();
    pulsePps();
    expSec = expSec + 1;
    tick(40);
    check("t5_no_events", evLog.size(), 0);
    check("t5_not_busy",  busy, 0);
    check("t5_seconds",   secondsNow, 32'h101);
    enable = 1'b1;
    pulsePps();
    expSec = expSec + 1;
    k = 0;
    while (evLog.size() < 4 && k < 200) begin tick(); k++; end
    enable = 1'b0;
    waitIdle("t5", 10);
    tick(BS * 3);
    check("t5_truncated_count", evLog.size(), 4);
    check("t5_valid_low", evCodeValid, 0);
    enable = 1'b1;

    // 6. Wrap, then loopback through the receiver model
    evLog.delete();
    secondsIn = 32'hFFFF_FFFE; secondsLoad = 1'b1;
    tick();
    secondsLoad = 1'b0;
    pulsePps();
    expSec = 32'hFFFF_FFFF;
    check("t6_seconds", secondsNow, expSec);
    waitEvents("t6", 1 + SW, 400);
    decodeSeq(1, val, bad);
    check("t6_wrap_value", val, 32'h0);
    waitIdle("t6", 20);
    for (int p = 0; p < 3; p++) begin
      evLog.delete();
      pulsePps();
      expSec = expSec + 1;
      check($sformatf("t6_loop%0d_seconds", p), secondsNow, expSec);
      waitEvents($sformatf("t6_loop%0d_marker", p), 1, 20);
      check($sformatf("t6_loop%0d_rx_valid", p), rxValid, 1);
      check($sformatf("t6_loop%0d_rx_seconds", p), rxSec, expSec);
      waitEvents($sformatf("t6_loop%0d", p), 1 + SW, 400);
      waitIdle($sformatf("t6_loop%0d", p), 20);
    end

    // 7. Reset mid-sequence drops valid without a transfer
    evCodeReady = 1'b0;
    pulsePps();
    check("t7_valid_before_rst", evCodeValid, 1);
    rst = 1'b1;
    tick();
    check("t7_valid_after_rst", evCodeValid, 0);
    check("t7_busy_after_rst",  busy, 0);
    check("t7_seconds_after_rst", secondsNow, 0);
    check("t7_overrun_after_rst", overrunCounter, 0);
    rst = 1'b0;
    evCodeReady = 1'b1;

    // 8. Watchdog: limit is 1010 clocks without pps
    tick(1000);
    check("t8_missed_before_limit", ppsMissedCounter, 0);
    tick(20);
    check("t8_missed_after_limit", ppsMissedCounter, 1);
    check("t8_no_events", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
